// File: rtl/ysyx_25020032_ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes,
// the reset PC and the word substituted for a faulted fetch.
package ysyx_25020032_ifu_fetch_pkg;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t S_FETCH = 2'd0;
  localparam ifu_state_t S_WAIT  = 2'd1;
  localparam ifu_state_t S_HOLD  = 2'd2;
  localparam ifu_state_t S_EXEC  = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] ILLEGAL_INSTR    = 32'h0000_0000;

  // A faulted fetch must not hand garbage to decode; substitute a fixed word.
  function automatic logic [31:0] fetch_word(input logic err, input logic [31:0] data);
    logic [31:0] w;
    if (err) begin
      w = ILLEGAL_INSTR;
    end else begin
      w = data;
    end
    return w;
  endfunction

endpackage

// File: rtl/ysyx_25020032_ifu_fetch_chk.sv
// Protocol checker for the fetch unit: writeback must only commit a next PC
// while the fetch unit is waiting for one.
module ysyx_25020032_ifu_fetch_chk
  import ysyx_25020032_ifu_fetch_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       en,
  input logic [1:0] state,
  input logic       npc_valid
);

  // Flag an npc commit that arrives outside the execute-wait state.
  always @(posedge clk) begin
    if (!rst && en) begin
      assert (!(npc_valid && (state != S_EXEC)));
    end
  end

endmodule

// File: rtl/ysyx_25020032_perf_counter.sv
// Saturating event counter with enable and synchronous active-high reset.
// Shared by the fetch unit and the LSU performance monitors.
module ysyx_25020032_perf_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance on enable, but stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_25020032_ifu_fetch.sv
// Multi-cycle instruction fetch unit: one outstanding imem read, hands
// {instr, pc} to decode, then waits for writeback to commit the next PC.
// Optional performance counters: define YSYX_25020032_IFU_PERF_EN.
module ysyx_25020032_ifu_fetch
  import ysyx_25020032_ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              ifu_valid,
  input  logic              idu_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
`ifdef YSYX_25020032_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cycles,
  output logic [63:0]       perf_err_cnt
`endif
);

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              fetch_err_q, fetch_err_d;
  // High for the cycle following a reset edge; keeps the request quiet
  // while rst is still asserted without a combinational path from rst.
  logic              rst_seen_q;

  assign imem_req_valid = (state_q == S_FETCH) && !rst_seen_q;
  assign imem_addr      = pc_q;
  assign ifu_valid      = (state_q == S_HOLD);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign fetch_err      = fetch_err_q;

  // Next-state and datapath updates for the fetch/wait/hold/exec sequence.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_valid && imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d     = fetch_word(imem_rsp_err, imem_rsp_data);
          fetch_err_d = imem_rsp_err;
          state_d     = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (idu_ready) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_EXEC: begin
        if (npc_valid) begin
          pc_d    = npc;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset restarts fetching at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= ILLEGAL_INSTR;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Remember that the previous edge was a reset edge.
  always_ff @(posedge clk) begin
    rst_seen_q <= rst;
  end

`ifdef YSYX_25020032_IFU_PERF_EN
  ysyx_25020032_perf_counter #(.W(64)) u_perf_fetch (
    .clk (clk),
    .rst (rst),
    .en  (ifu_valid && idu_ready),
    .cnt (perf_fetch_cnt)
  );

  ysyx_25020032_perf_counter #(.W(64)) u_perf_wait (
    .clk (clk),
    .rst (rst),
    .en  ((state_q == S_FETCH) || (state_q == S_WAIT)),
    .cnt (perf_wait_cycles)
  );

  ysyx_25020032_perf_counter #(.W(64)) u_perf_err (
    .clk (clk),
    .rst (rst),
    .en  ((state_q == S_WAIT) && imem_rsp_valid && imem_rsp_err),
    .cnt (perf_err_cnt)
  );

  // End-of-run counter summary.
  final begin
    $display("ifu perf: fetches=%0d wait_cycles=%0d err_rsps=%0d",
             perf_fetch_cnt, perf_wait_cycles, perf_err_cnt);
  end
`endif

endmodule
